// File: rtl/mul_issue_pkg.sv
// Shared RV32M multiply types for the execute-stage issue logic.
// Multiply operand signedness, issue FSM states and funct3 codes.
package rv32imc_types;

    typedef enum logic [1:0] {
        MUL_SS = 2'd0,
        MUL_SU = 2'd1,
        MUL_UU = 2'd2
    } mul_type_t;

    typedef enum logic [1:0] {
        MI_IDLE  = 2'd0,
        MI_RUN   = 2'd1,
        MI_HOLD  = 2'd2,
        MI_DRAIN = 2'd3
    } muliss_state_t;

    localparam logic [2:0] mulr    = 3'b000;
    localparam logic [2:0] mulhr   = 3'b001;
    localparam logic [2:0] mulhsur = 3'b010;
    localparam logic [2:0] mulhur  = 3'b011;

endpackage

// File: rtl/mul_issue_funct3_decode.sv
// RV32M funct3 to multiplier operand signedness.
// Low-word MUL runs unsigned; funct3[2] set is not a multiply.
module mul_funct3_decode
    import rv32imc_types::*;
(
    input  logic [2:0] funct3,
    output mul_type_t  mul_type,
    output logic       illegal
);

    always_comb begin
        mul_type = MUL_UU;
        illegal  = funct3[2];
        unique case (1'b1)
            funct3 == mulhr:   mul_type = MUL_SS;
            funct3 == mulhsur: mul_type = MUL_SU;
            default:           mul_type = MUL_UU;
        endcase
    end

endmodule

// File: rtl/mul_issue.sv
// Execute-stage sequencer in front of the multiplier: issue,
// completion capture, result hold and flush absorption.
module mul_issue
    import rv32imc_types::*;
#(
    parameter int WDOG_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_start,
    output logic [2:0]  mul_op,
    output logic [2:0]  mul_funct3,
    input  logic [31:0] mul_fout,
    input  logic        mul_stall,
    output logic        err_timeout
);

    localparam int WW = $clog2(WDOG_MAX + 1);

    muliss_state_t state, state_n;
    mul_type_t     dec_type;
    logic          dec_ill;
    logic          ill_q;
    logic          done;
    logic          accept;
    logic          wd_entry;
    logic          wd_active;
    logic [WW-1:0] wd_cnt;

    mul_funct3_decode u_dec (
        .funct3   (req_funct3),
        .mul_type (dec_type),
        .illegal  (dec_ill)
    );

    assign done   = ~mul_stall;
    assign accept = req_valid & req_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) state <= MI_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            MI_IDLE:
                if (accept) state_n = MI_RUN;
            MI_RUN:
                // a flush racing completion simply discards the result
                if (done)       state_n = flush ? MI_IDLE : MI_HOLD;
                else if (flush) state_n = MI_DRAIN;
            MI_HOLD:
                if (flush)          state_n = MI_IDLE;
                else if (rsp_ready) state_n = accept ? MI_RUN : MI_IDLE;
            MI_DRAIN:
                if (done) state_n = MI_IDLE;
            default:
                state_n = MI_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mul_start = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            MI_IDLE:  req_ready = rst;
            MI_RUN:   mul_start = 1'b1;
            MI_DRAIN: mul_start = 1'b1;
            MI_HOLD: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready & ~flush;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            mul_funct3 <= '0;
            mul_op     <= '0;
            rsp_rd     <= '0;
            rsp_data   <= '0;
            ill_q      <= 1'b0;
        end else begin
            if (accept) begin
                mul_a      <= req_a;
                mul_b      <= req_b;
                mul_funct3 <= req_funct3;
                mul_op     <= {1'b0, dec_type};
                rsp_rd     <= req_rd;
                ill_q      <= dec_ill;
            end
            if (state == MI_RUN && done && !flush)
                rsp_data <= ill_q ? '0 : mul_fout;
        end
    end

    assign wd_active = (state == MI_RUN) || (state == MI_DRAIN);
    assign wd_entry  = (state_n != state) &&
                       (state_n == MI_RUN || state_n == MI_DRAIN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (wd_entry)
                wd_cnt <= '0;
            else if (wd_active && wd_cnt != WW'(WDOG_MAX))
                wd_cnt <= wd_cnt + WW'(1);
            if (wd_cnt == WW'(WDOG_MAX))
                err_timeout <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst && accept)
            assert (!req_funct3[2])
            else $error("mul_issue: illegal funct3 %b", req_funct3);
    end

endmodule

// File: tb/tb_mul_issue.sv
// Scoreboard bench for mul_issue driving a DEPTH=2 multiplier model.
module tb_mul_issue;
    import rv32imc_types::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_start;
    logic [2:0]  mul_op;
    logic [2:0]  mul_funct3;
    logic [31:0] mul_fout;
    logic        mul_stall;
    logic        err_timeout;

    logic        hang;
    logic [2:0]  mcnt;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    mul_issue #(.WDOG_MAX(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_funct3  (req_funct3),
        .req_rd      (req_rd),
        .flush       (flush),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_rd      (rsp_rd),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_start   (mul_start),
        .mul_op      (mul_op),
        .mul_funct3  (mul_funct3),
        .mul_fout    (mul_fout),
        .mul_stall   (mul_stall),
        .err_timeout (err_timeout)
    );

    // Multiplier model: result ready in the fifth start cycle
    function automatic logic [31:0] mfun(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  op,
        input logic [2:0]  f3
    );
        logic signed [65:0] sa, sb, p;
        sa = (op[1:0] != 2'd2) ? {{34{a[31]}}, a} : {34'd0, a};
        sb = (op[1:0] == 2'd0) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = sa * sb;
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    always @(posedge clk) begin
        if (!rst || !mul_start)      mcnt <= '0;
        else if (mcnt == 3'(DEPTH + 2)) mcnt <= hang ? mcnt : 3'd0;
        else                         mcnt <= mcnt + 3'd1;
    end

    assign mul_stall = mul_start && (hang || mcnt != 3'(DEPTH + 2));
    assign mul_fout  = mfun(mul_a, mul_b, mul_op, mul_funct3);

    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready && !flush) begin
            vecs++;
            if (sbq.size() == 0) begin
                errs++;
                $display("FAIL sb_empty got=%h rd=%0d want=none",
                         rsp_data, rsp_rd);
            end else begin
                e = sbq.pop_front();
                if (rsp_data !== e.data || rsp_rd !== e.rd) begin
                    errs++;
                    $display("FAIL sb_rsp got=%h/%0d want=%h/%0d",
                             rsp_data, rsp_rd, e.data, e.rd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [31:0] exp_d,
        input bit          push
    );
        int n;
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_funct3 = f3;
        req_rd     = rd;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        vecs++;
        if (n >= 50) begin
            errs++;
            $display("FAIL accept_timeout got=%0d want<50", n);
        end
        if (push) sbq.push_back({rd, exp_d});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        vecs++;
        if ({req_ready, rsp_valid, mul_start, err_timeout} !== 4'b0) begin
            errs++;
            $display("FAIL reset_ctl got=%b want=0000",
                     {req_ready, rsp_valid, mul_start, err_timeout});
        end
        vecs++;
        if ({mul_a, mul_b, rsp_data, rsp_rd, mul_op, mul_funct3}
            !== '0) begin
            errs++;
            $display("FAIL reset_data got=%h/%h/%h/%0d/%0d/%0d want=0",
                     mul_a, mul_b, rsp_data, rsp_rd, mul_op, mul_funct3);
        end
        rst = 1'b1;
        #1;
        vecs++;
        if (req_ready !== 1'b1) begin
            errs++;
            $display("FAIL idle_ready got=%b want=1", req_ready);
        end
    endtask

    task automatic test_basic();
        int n;
        rsp_ready = 1'b1;
        issue(32'd7, 32'd6, mulr, 5'd5, 32'h0000_002A, 1'b1);
        vecs++;
        if (mul_start !== 1'b1) begin
            errs++;
            $display("FAIL start_rise got=%b want=1", mul_start);
        end
        wait_rsp(n);
        vecs++;
        if (n !== 6) begin
            errs++;
            $display("FAIL latency got=%0d want=6", n);
        end
        vecs++;
        if (mul_start !== 1'b0) begin
            errs++;
            $display("FAIL start_fall got=%b want=0", mul_start);
        end
        tick();
        vecs++;
        if (rsp_valid !== 1'b0 || mul_start !== 1'b0) begin
            errs++;
            $display("FAIL retire_idle got=%b%b want=00",
                     rsp_valid, mul_start);
        end
    endtask

    task automatic test_high_words();
        int n;
        rsp_ready = 1'b1;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, mulhr, 5'd10,
              32'h0000_0000, 1'b1);
        wait_rsp(n);
        tick();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, mulhur, 5'd11,
              32'hFFFF_FFFE, 1'b1);
        wait_rsp(n);
        tick();
        issue(32'hFFFF_FFFF, 32'd2, mulhsur, 5'd12,
              32'hFFFF_FFFF, 1'b1);
        wait_rsp(n);
        vecs++;
        if (n !== 6) begin
            errs++;
            $display("FAIL mulhsu_latency got=%0d want=6", n);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        rsp_ready = 1'b0;
        issue(32'd9, 32'd9, mulr, 5'd3, 32'h0000_0051, 1'b1);
        wait_rsp(n);
        req_valid  = 1'b1;
        req_a      = 32'd3;
        req_b      = 32'd5;
        req_funct3 = mulr;
        req_rd     = 5'd13;
        #1;
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h51 ||
                req_ready !== 1'b0) begin
                errs++;
                $display("FAIL hold_stable got=%b/%h/%b want=1/51/0",
                         rsp_valid, rsp_data, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        vecs++;
        if (req_ready !== 1'b1) begin
            errs++;
            $display("FAIL b2b_ready got=%b want=1", req_ready);
        end
        sbq.push_back({5'd13, 32'h0000_000F});
        tick();
        req_valid = 1'b0;
        vecs++;
        if (mul_start !== 1'b1 || rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL b2b_run got=%b%b want=10",
                     mul_start, rsp_valid);
        end
        wait_rsp(n);
        vecs++;
        if (n !== 6) begin
            errs++;
            $display("FAIL b2b_latency got=%0d want=6", n);
        end
        tick();
    endtask

    task automatic test_flush_run();
        int  n;
        bit  seen;
        rsp_ready = 1'b1;
        issue(32'h1234, 32'h10, mulr, 5'd7, 32'h0, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        vecs++;
        if ({mul_start, rsp_valid, req_ready} !== 3'b100) begin
            errs++;
            $display("FAIL drain_state got=%b want=100",
                     {mul_start, rsp_valid, req_ready});
        end
        n    = 0;
        seen = 1'b0;
        while (mul_start && n < 20) begin
            tick();
            seen |= rsp_valid;
            n++;
        end
        vecs++;
        if (n !== 3) begin
            errs++;
            $display("FAIL drain_len got=%0d want=3", n);
        end
        vecs++;
        if (seen !== 1'b0 || rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL drain_rsp got=%b want=0", seen);
        end
        issue(32'h11, 32'h3, mulr, 5'd4, 32'h0000_0033, 1'b1);
        wait_rsp(n);
        vecs++;
        if (n !== 6) begin
            errs++;
            $display("FAIL post_drain got=%0d want=6", n);
        end
        tick();
    endtask

    task automatic test_flush_hold();
        int n;
        rsp_ready = 1'b0;
        issue(32'd2, 32'd2, mulr, 5'd9, 32'h0, 1'b0);
        wait_rsp(n);
        flush      = 1'b1;
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        req_a      = 32'd1;
        req_b      = 32'd1;
        req_funct3 = mulr;
        req_rd     = 5'd2;
        #1;
        vecs++;
        if (req_ready !== 1'b0) begin
            errs++;
            $display("FAIL hold_flush_ready got=%b want=0", req_ready);
        end
        tick();
        #1;
        vecs++;
        if (rsp_valid !== 1'b0 || mul_start !== 1'b0) begin
            errs++;
            $display("FAIL hold_flush_idle got=%b%b want=00",
                     rsp_valid, mul_start);
        end
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        vecs++;
        if (mul_start !== 1'b0 || req_ready !== 1'b1) begin
            errs++;
            $display("FAIL flush_req_dropped got=%b%b want=01",
                     mul_start, req_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        rsp_ready = 1'b1;
        issue(32'd5, 32'd5, mulhur, 5'd21, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        vecs++;
        if ({req_ready, rsp_valid, mul_start, err_timeout} !== 4'b0) begin
            errs++;
            $display("FAIL rst_mid_ctl got=%b want=0000",
                     {req_ready, rsp_valid, mul_start, err_timeout});
        end
        vecs++;
        if ({mul_a, mul_b, rsp_data, rsp_rd, mul_op, mul_funct3}
            !== '0) begin
            errs++;
            $display("FAIL rst_mid_data got=%h/%h/%h/%0d/%0d/%0d want=0",
                     mul_a, mul_b, rsp_data, rsp_rd, mul_op, mul_funct3);
        end
        rst = 1'b1;
        issue(32'h8000_0000, 32'd2, mulr, 5'd31, 32'h0, 1'b1);
        wait_rsp(n);
        vecs++;
        if (n !== 6) begin
            errs++;
            $display("FAIL post_rst_latency got=%0d want=6", n);
        end
        tick();
        vecs++;
        if (err_timeout !== 1'b0) begin
            errs++;
            $display("FAIL no_timeout got=%b want=0", err_timeout);
        end
    endtask

    task automatic test_watchdog();
        int n;
        rsp_ready = 1'b1;
        hang      = 1'b1;
        issue(32'd4, 32'd4, mulr, 5'd1, 32'h0000_0010, 1'b1);
        for (int i = 0; i < 16; i++) tick();
        vecs++;
        if (err_timeout !== 1'b0) begin
            errs++;
            $display("FAIL wdog_early got=%b want=0", err_timeout);
        end
        tick();
        vecs++;
        if (err_timeout !== 1'b1) begin
            errs++;
            $display("FAIL wdog_fire got=%b want=1", err_timeout);
        end
        hang = 1'b0;
        wait_rsp(n);
        tick();
        vecs++;
        if (err_timeout !== 1'b1) begin
            errs++;
            $display("FAIL wdog_sticky got=%b want=1", err_timeout);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        vecs++;
        if (err_timeout !== 1'b0) begin
            errs++;
            $display("FAIL wdog_clear got=%b want=0", err_timeout);
        end
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_funct3 = '0;
        req_rd     = '0;
        flush      = 1'b0;
        rsp_ready  = 1'b0;
        hang       = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_high_words();
        test_back_to_back();
        test_flush_run();
        test_flush_hold();
        test_reset_mid_run();
        test_watchdog();
        tick();
        vecs++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL sb_leftover got=%0d want=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

endmodule
